// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address-decode helpers for the data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 2;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    // Addresses are passed zero-extended to 32 bits so one helper serves any ADDR_W.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
        return (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
        return addr >> (OFFSET_W + idx_w);
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: one combinational read port, one synchronous fill-or-word write port.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = 3
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic [IDX_W-1:0]    idx_i,
    output logic                rd_valid_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output logic [LINE_W-1:0]   rd_data_o,
    input  logic                fill_en_i,
    input  logic [TAG_W-1:0]    fill_tag_i,
    input  logic [LINE_W-1:0]   fill_data_i,
    input  logic                word_en_i,
    input  logic [OFFSET_W-1:0] word_off_i,
    input  logic [WORD_W-1:0]   word_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[idx_i];

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Reset blocks array writes so an aborted transfer leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_ni) begin
            if (fill_en_i) begin
                tag_q[idx_i]  <= fill_tag_i;
                data_q[idx_i] <= fill_data_i;
            end else if (word_en_i) begin
                data_q[idx_i][WORD_W*word_off_i +: WORD_W] <= word_data_i;
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to implement the hit/miss counters; otherwise they read as zero.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LINES   = 32,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic               cpu_rd_en,
    input  logic               cpu_wr_en,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               stall,
    output logic [ADDR_W-1:0]  mem_word_address,
    output logic [WORD_W-1:0]  mem_data_in,
    output logic               mem_read,
    output logic               mem_we,
    output logic               mem_stall,
    input  logic [BLOCK_W-1:0] mem_rd_block,
    input  logic               mem_ready,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
);

    // state | meaning
    // IDLE  | serve read hits combinationally, accept new misses and writes
    // FILL  | block read from memory in flight for the latched address
    // WRITE | word write-through to memory in flight for the latched address

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic [ADDR_W-1:0]   req_addr;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [OFFSET_W-1:0] req_off;
    logic                ls_valid;
    logic [TAG_W-1:0]    ls_tag;
    logic [BLOCK_W-1:0]  ls_data;
    logic                hit;
    logic                fill_en;
    logic                word_en;

    // In IDLE the array is probed with the live CPU address; otherwise with the latched one.
    assign req_addr = (state_q == IDLE) ? cpu_addr : addr_q;
    assign req_idx  = IDX_W'(addr_index(32'(req_addr), IDX_W));
    assign req_tag  = TAG_W'(addr_tag(32'(req_addr), IDX_W));
    assign req_off  = addr_offset(32'(req_addr));
    assign hit      = ls_valid && (ls_tag == req_tag);

    assign mem_word_address = addr_q;
    assign mem_data_in      = wdata_q;

    dcache_line_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_line_store (
        .clk         (clk),
        .rst_ni      (rst),
        .idx_i       (req_idx),
        .rd_valid_o  (ls_valid),
        .rd_tag_o    (ls_tag),
        .rd_data_o   (ls_data),
        .fill_en_i   (fill_en),
        .fill_tag_i  (req_tag),
        .fill_data_i (mem_rd_block),
        .word_en_i   (word_en),
        .word_off_i  (req_off),
        .word_data_i (wdata_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        stall     = 1'b0;
        cpu_rdata = '0;
        mem_read  = 1'b0;
        mem_we    = 1'b0;
        mem_stall = 1'b0;
        fill_en   = 1'b0;
        word_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_wr_en) begin
                    stall   = 1'b1;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = WRITE;
                end else if (cpu_rd_en) begin
                    if (hit) begin
                        cpu_rdata = ls_data[WORD_W*req_off +: WORD_W];
                    end else begin
                        stall   = 1'b1;
                        addr_d  = cpu_addr;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                mem_read  = 1'b1;
                mem_stall = 1'b1;
                stall     = 1'b1;
                if (mem_ready) begin
                    stall     = 1'b0;
                    cpu_rdata = mem_rd_block[WORD_W*req_off +: WORD_W];
                    fill_en   = 1'b1;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_stall = 1'b1;
                stall     = 1'b1;
                if (mem_ready) begin
                    stall   = 1'b0;
                    word_en = hit;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q, miss_q;
    logic        hit_inc, miss_inc;

    assign hit_inc  = (state_q == IDLE) && cpu_rd_en && !cpu_wr_en && hit;
    assign miss_inc = (state_q == IDLE) && cpu_rd_en && !cpu_wr_en && !hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit_inc && (hit_q != 16'hFFFF)) hit_q <= hit_q + 16'd1;
            if (miss_inc && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a cache/memory reference model checked every cycle.
module tb_dcache_controller;

    localparam int LINES = 32;
    localparam int IDXW  = 5;
`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   cpu_addr;
    logic         cpu_rd_en, cpu_wr_en;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         stall;
    logic [9:0]   mem_word_address;
    logic [31:0]  mem_data_in;
    logic         mem_read, mem_we, mem_stall;
    logic [127:0] mem_rd_block;
    logic         mem_ready;
    logic [15:0]  hit_count, miss_count;

    int nvec = 0;
    int nerr = 0;
    int mem_lat = 0;

    logic [31:0] mem [1024];

    int          m_valid [LINES];
    int          m_tag   [LINES];
    logic [31:0] m_data  [LINES][4];
    int          busy;
    logic [9:0]  lat_a;
    logic [31:0] lat_d;
    int          m_hits, m_miss;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_addr         (cpu_addr),
        .cpu_rd_en        (cpu_rd_en),
        .cpu_wr_en        (cpu_wr_en),
        .cpu_wdata        (cpu_wdata),
        .cpu_rdata        (cpu_rdata),
        .stall            (stall),
        .mem_word_address (mem_word_address),
        .mem_data_in      (mem_data_in),
        .mem_read         (mem_read),
        .mem_we           (mem_we),
        .mem_stall        (mem_stall),
        .mem_rd_block     (mem_rd_block),
        .mem_ready        (mem_ready),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Data memory: replies mem_lat cycles after a transfer starts; block comes from the shared mem image.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rd_block = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (rst && (mem_read || mem_we)) begin
                cnt++;
                if (cnt > mem_lat) begin
                    mem_ready = 1'b1;
                    for (int k = 0; k < 4; k++)
                        mem_rd_block[32*k +: 32] = mem[(int'(mem_word_address) & ~3) + k];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Reference model: evaluated at each negedge on the inputs the next posedge will sample.
    initial begin
        logic        e_stall, e_mr, e_mw, e_ms;
        logic [31:0] e_rdata;
        int          li, lt;
        bit          mhit;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
        busy = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0;
                m_hits = 0;
                m_miss = 0;
                for (int i = 0; i < LINES; i++) m_valid[i] = 0;
                continue;
            end
            e_stall = 1'b0; e_rdata = '0; e_mr = 1'b0; e_mw = 1'b0; e_ms = 1'b0;
            li = (busy == 0) ? (int'(cpu_addr) >> 2) % LINES : (int'(lat_a) >> 2) % LINES;
            lt = (busy == 0) ? int'(cpu_addr) >> (2 + IDXW) : int'(lat_a) >> (2 + IDXW);
            mhit = (m_valid[li] != 0) && (m_tag[li] == lt);
            if (busy == 0) begin
                if (cpu_wr_en) e_stall = 1'b1;
                else if (cpu_rd_en) begin
                    if (mhit) e_rdata = m_data[li][int'(cpu_addr) % 4];
                    else e_stall = 1'b1;
                end
            end else begin
                e_ms = 1'b1;
                e_stall = !mem_ready;
                if (busy == 1) begin
                    e_mr = 1'b1;
                    if (mem_ready) e_rdata = mem[int'(lat_a)];
                end else begin
                    e_mw = 1'b1;
                    chk("mem_data_in", mem_data_in, lat_d);
                end
                chk("mem_word_address", 32'(mem_word_address), 32'(lat_a));
            end
            chk("stall", 32'(stall), 32'(e_stall));
            chk("cpu_rdata", cpu_rdata, e_rdata);
            chk("mem_read", 32'(mem_read), 32'(e_mr));
            chk("mem_we", 32'(mem_we), 32'(e_mw));
            chk("mem_stall", 32'(mem_stall), 32'(e_ms));
            chk("hit_count", 32'(hit_count), STATS ? m_hits : 0);
            chk("miss_count", 32'(miss_count), STATS ? m_miss : 0);
            // advance the model across the coming posedge
            if (busy == 0) begin
                if (cpu_wr_en) begin
                    busy = 2; lat_a = cpu_addr; lat_d = cpu_wdata;
                end else if (cpu_rd_en) begin
                    if (mhit) begin
                        if (m_hits < 65535) m_hits++;
                    end else begin
                        if (m_miss < 65535) m_miss++;
                        busy = 1; lat_a = cpu_addr;
                    end
                end
            end else if (mem_ready) begin
                if (busy == 1) begin
                    m_valid[li] = 1;
                    m_tag[li] = lt;
                    for (int k = 0; k < 4; k++) m_data[li][k] = mem[(int'(lat_a) & ~3) + k];
                end else begin
                    mem[int'(lat_a)] = lat_d;
                    if (mhit) m_data[li][int'(lat_a) % 4] = lat_d;
                end
                busy = 0;
            end
        end
    end

    // Issue one request at posedge+1 and hold it until the cycle stall is low.
    task automatic req(input logic [9:0] a, input logic rd, input logic wr, input logic [31:0] d,
                       input int lat, output int stalls, output logic [31:0] rdata);
        bit done;
        done = 0;
        stalls = 0;
        rdata = 'x;
        mem_lat = lat;
        cpu_addr = a; cpu_rd_en = rd; cpu_wr_en = wr; cpu_wdata = d;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            else begin
                done = 1;
                rdata = cpu_rdata;
            end
        end
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL req_timeout: stall still %b after 64 cycles, expected low, addr %h", stall, a);
        end
        @(posedge clk);
        #1;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        rst = 1'b0;
        cpu_addr = '0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        @(posedge clk);
        #1;

        req(10'h004, 1'b1, 1'b0, '0, 3, st, rd);
        chk("miss_stall_cycles", st, 4);
        chk("miss_rdata", rd, 32'hC0DE_0004);
        chk("miss_count_1", 32'(miss_count), STATS ? 32'd1 : 32'd0);

        req(10'h005, 1'b1, 1'b0, '0, 3, st, rd);
        chk("hit_stall_cycles", st, 0);
        chk("hit_rdata", rd, 32'hC0DE_0005);
        chk("hit_count_1", 32'(hit_count), STATS ? 32'd1 : 32'd0);

        req(10'h005, 1'b0, 1'b1, 32'hDEAD_BEEF, 2, st, rd);
        chk("write_hit_stall_cycles", st, 3);
        req(10'h005, 1'b1, 1'b0, '0, 2, st, rd);
        chk("reread_after_write", rd, 32'hDEAD_BEEF);
        chk("reread_stall_cycles", st, 0);

        // rd and wr together: the write wins and does not allocate
        req(10'h3F0, 1'b1, 1'b1, 32'h1234_5678, 0, st, rd);
        chk("write_miss_stall_cycles", st, 1);
        repeat (2) @(posedge clk);
        #1;
        req(10'h3F0, 1'b1, 1'b0, '0, 1, st, rd);
        chk("no_allocate_stall_cycles", st, 2);
        chk("no_allocate_rdata", rd, 32'h1234_5678);

        req(10'h004, 1'b1, 1'b0, '0, 2, st, rd);
        chk("line1_hit_cycles", st, 0);
        req(10'h084, 1'b1, 1'b0, '0, 4, st, rd);
        chk("evict_stall_cycles", st, 5);
        chk("evict_rdata", rd, 32'hC0DE_0084);
        req(10'h004, 1'b1, 1'b0, '0, 2, st, rd);
        chk("evicted_stall_cycles", st, 3);
        chk("evicted_rdata", rd, 32'hC0DE_0004);
        chk("hit_count_3", 32'(hit_count), STATS ? 32'd3 : 32'd0);
        chk("miss_count_4", 32'(miss_count), STATS ? 32'd4 : 32'd0);

        // reset in the middle of a fill
        mem_lat = 20;
        cpu_addr = 10'h084; cpu_rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_rd_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_mem_read", 32'(mem_read), 32'd0);
        @(posedge clk);
        #1;
        req(10'h004, 1'b1, 1'b0, '0, 1, st, rd);
        chk("post_reset_miss_cycles", st, 2);
        chk("post_reset_rdata", rd, 32'hC0DE_0004);
        chk("post_reset_miss_count", 32'(miss_count), STATS ? 32'd1 : 32'd0);
        chk("post_reset_hit_count", 32'(hit_count), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
